mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide execute unit. It sits directly downstream of the register file: it takes the two register read values as operands plus the destination register index, and returns a 32-bit result and that index for write-back into the register file. The unit has a fixed 34-cycle latency, so the hazard and stall logic can treat it as a fixed-latency operation.

---
 rtl/mul_div_unit_if.sv | 18 +
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_mul_div_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issue stage and the iterative mul/div unit.
interface mul_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic [4:0]      rdIn;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rdOut;

  modport master (output start, flush, op, rs1Data, rs2Data, rdIn,
                  input  busy, done, result, rdOut);
  modport slave  (input  start, flush, op, rs1Data, rs2Data, rdIn,
                  output busy, done, result, rdOut);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide,
// one bit per cycle, fixed 34-cycle start-to-done latency.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;        // mul: {partial, multiplier}; div: low word = dividend/quotient
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic            accept;
  logic            sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0] in_mag_a, in_mag_b;

  always_comb begin
    accept   = bus.start & ~bus.flush & ((state == S_IDLE) | (state == S_DONE));
    sgn_a    = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    sgn_b    = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
    in_neg_a = sgn_a & bus.rs1Data[XLEN-1];
    in_neg_b = sgn_b & bus.rs2Data[XLEN-1];
    in_mag_a = in_neg_a ? -bus.rs1Data : bus.rs1Data;
    in_mag_b = in_neg_b ? -bus.rs2Data : bus.rs2Data;
  end

  // One iteration of each datapath; the FSM picks which one commits.
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shl;
  logic            div_ge;
  logic [XLEN:0]   div_rem;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shl = {rem, acc[XLEN-1]};
    div_ge  = div_shl >= {2'b0, mag_b};
    div_rem = (XLEN+1)'(div_ge ? div_shl - {2'b0, mag_b} : div_shl);
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rmd, a_orig, fix_res;
  logic              div_zero, div_ovf;

  always_comb begin
    prod_s   = (neg_a ^ neg_b) ? -acc : acc;
    a_orig   = neg_a ? -mag_a : mag_a;
    div_zero = (mag_b == '0);
    div_ovf  = ~op_q[0] & neg_a & neg_b &
               (mag_a == {1'b1, {(XLEN-1){1'b0}}}) & (mag_b == XLEN'(1));
    if (div_zero) begin
      quo = '1;
      rmd = a_orig;
    end else if (div_ovf) begin
      quo = {1'b1, {(XLEN-1){1'b0}}};
      rmd = '0;
    end else begin
      quo = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rmd = neg_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end
    if (op_q[2])
      fix_res = op_q[1] ? rmd : quo;
    else
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      rem      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state <= S_CALC;
            cnt   <= '0;
            op_q  <= bus.op;
            rd_q  <= bus.rdIn;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            rem   <= '0;
            acc   <= {{XLEN{1'b0}}, bus.op[2] ? in_mag_a : in_mag_b};
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              rem <= div_rem;
              acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(XLEN-1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            state    <= S_DONE;
            result_q <= fix_res;
            rd_out_q <= rd_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_CALC) | (state == S_FIX);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
  assign bus.rdOut  = rd_out_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, flush, reset and back-to-back issue.
module tb_mul_div_unit;
  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(XLEN)) bus();
  mul_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Presents a request for exactly one edge; call #1 after an edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.op = op; bus.rs1Data = a; bus.rs2Data = b; bus.rdIn = rd; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // lat counts edges from the accepting edge (1) to the edge that raised done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) c++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.rs1Data = '0; bus.rs2Data = '0; bus.rdIn = '0;
    #12;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL reset_result got %h want 0", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rdOut !== 5'd0) $display("FAIL reset_rdout got %0d want 0", bus.rdOut); else pass_cnt++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [2:0]  ops[3];
    logic [31:0] va[3], vb[3], ve[3];
    logic [4:0]  vr[3];
    int lat;
    ops = '{OP_MUL, OP_MULHU, OP_MULH};
    va  = '{32'd7, 32'hFFFFFFFF, 32'h80000000};
    vb  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    ve  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000};
    vr  = '{5'd1, 5'd17, 5'd31};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], va[i], vb[i], vr[i]);
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mul%0d_busy got %b want 1", i, bus.busy); else pass_cnt++;
      wait_done(lat);
      total_cnt++; if (lat != 34) $display("FAIL mul%0d_latency got %0d want 34", i, lat); else pass_cnt++;
      total_cnt++; if (bus.result !== ve[i]) $display("FAIL mul%0d_result got %h want %h", i, bus.result, ve[i]); else pass_cnt++;
      total_cnt++; if (bus.rdOut !== vr[i]) $display("FAIL mul%0d_rdout got %0d want %0d", i, bus.rdOut, vr[i]); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mul%0d_busy_at_done got %b want 0", i, bus.busy); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL mul%0d_done_pulse got %b want 0", i, bus.done); else pass_cnt++;
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops[4];
    logic [31:0] va[4], vb[4], ve[4];
    int lat;
    ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    va  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    vb  = '{32'd2, 32'd2, 32'd7, 32'd7};
    ve  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], va[i], vb[i], 5'(i + 4));
      wait_done(lat);
      total_cnt++; if (lat != 34) $display("FAIL div%0d_latency got %0d want 34", i, lat); else pass_cnt++;
      total_cnt++; if (bus.result !== ve[i]) $display("FAIL div%0d_result got %h want %h", i, bus.result, ve[i]); else pass_cnt++;
      total_cnt++; if (bus.rdOut !== 5'(i + 4)) $display("FAIL div%0d_rdout got %0d want %0d", i, bus.rdOut, i + 4); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops[5];
    logic [31:0] va[5], vb[5], ve[5];
    int lat;
    ops = '{OP_DIV, OP_REMU, OP_REM, OP_DIV, OP_REM};
    va  = '{32'd5, 32'd5, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    vb  = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ve  = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFF9, 32'h80000000, 32'd0};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], va[i], vb[i], 5'd12);
      wait_done(lat);
      total_cnt++; if (lat != 34) $display("FAIL special%0d_latency got %0d want 34", i, lat); else pass_cnt++;
      total_cnt++; if (bus.result !== ve[i]) $display("FAIL special%0d_result got %h want %h", i, bus.result, ve[i]); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_operand_change;
    int lat, n;
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd7);
    repeat (5) begin @(posedge clk); #1; end
    // Scramble operands and pulse a start that must be ignored.
    bus.rs1Data = 32'h12345678; bus.rs2Data = 32'h9; bus.op = OP_MUL; bus.rdIn = 5'd20;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL opchg_busy got %b want 1", bus.busy); else pass_cnt++;
    wait_done(lat);
    total_cnt++; if (lat != 28) $display("FAIL opchg_latency got %0d want 28", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'hFFFFFFFF) $display("FAIL opchg_result got %h want ffffffff", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rdOut !== 5'd7) $display("FAIL opchg_rdout got %0d want 7", bus.rdOut); else pass_cnt++;
    count_done(40, n);
    total_cnt++; if (n != 0) $display("FAIL busy_start_extra_done got %0d want 0", n); else pass_cnt++;
  endtask

  task automatic test_flush;
    int lat, n;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3);
    wait_done(lat);
    total_cnt++; if (bus.result !== 32'd14) $display("FAIL flush_pre_result got %h want e", bus.result); else pass_cnt++;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MUL; bus.rdIn = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL flush_idle_suppress got %b want 0", bus.busy); else pass_cnt++;
    issue(OP_MUL, 32'd6, 32'd7, 5'd9);
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL flush_busy got %b want 0", bus.busy); else pass_cnt++;
    count_done(40, n);
    total_cnt++; if (n != 0) $display("FAIL flush_done_count got %0d want 0", n); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'd14) $display("FAIL flush_result_kept got %h want e", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rdOut !== 5'd3) $display("FAIL flush_rdout_kept got %0d want 3", bus.rdOut); else pass_cnt++;
    issue(OP_MUL, 32'd6, 32'd7, 5'd9);
    wait_done(lat);
    total_cnt++; if (lat != 34) $display("FAIL post_flush_latency got %0d want 34", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'd42) $display("FAIL post_flush_result got %h want 2a", bus.result); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rstmid_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL rstmid_result got %h want 0", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rdOut !== 5'd0) $display("FAIL rstmid_rdout got %0d want 0", bus.rdOut); else pass_cnt++;
    #2 reset = 1'b1;
    count_done(40, n);
    total_cnt++; if (n != 0) $display("FAIL rstmid_done_count got %0d want 0", n); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.op = OP_MUL; bus.rs1Data = 32'd6; bus.rs2Data = 32'd7; bus.rdIn = 5'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    total_cnt++; if (lat != 34) $display("FAIL b2b0_latency got %0d want 34", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'd42) $display("FAIL b2b0_result got %h want 2a", bus.result); else pass_cnt++;
    bus.op = OP_DIVU; bus.rs1Data = 32'd100; bus.rs2Data = 32'd7; bus.rdIn = 5'd2;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b1_accept got %b want 1", bus.busy); else pass_cnt++;
    wait_done(lat);
    total_cnt++; if (lat != 34) $display("FAIL b2b1_latency got %0d want 34", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'd14) $display("FAIL b2b1_result got %h want e", bus.result); else pass_cnt++;
    total_cnt++; if (bus.rdOut !== 5'd2) $display("FAIL b2b1_rdout got %0d want 2", bus.rdOut); else pass_cnt++;
    bus.op = OP_REMU; bus.rdIn = 5'd4;
    @(posedge clk); #1;
    wait_done(lat);
    total_cnt++; if (lat != 34) $display("FAIL b2b2_latency got %0d want 34", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'd2) $display("FAIL b2b2_result got %h want 2", bus.result); else pass_cnt++;
    bus.start = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL b2b_idle busy=%b done=%b want 0/0", bus.busy, bus.done); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_operand_change;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
